flop_e: RTL and testbench

//  Decode->Execute pipeline register for the 5-stage RV32I core; feeds the Execute stage and, through it, the E->M control register.

---
 rtl/flop_e_if.sv | 57 +++++
 rtl/flop_e.sv | 87 ++++++++
 tb/tb_flop_e.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/flop_e_if.sv
// Decode->Execute pipeline register bus: Decode-side fields in, Execute-side fields out.
// master drives the D fields and observes E; slave is the pipeline register itself.
interface flop_e_if #(
    parameter int XLEN = 32
);
    logic            ValidD;
    logic            RegWriteD;
    logic [1:0]      ResultSrcD;
    logic            MemWriteD;
    logic            JumpD;
    logic            BranchD;
    logic [2:0]      ALUControlD;
    logic            ALUSrcD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] ImmExtD;
    logic [XLEN-1:0] PCPlus4D;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;

    logic            ValidE;
    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;

    modport master (
        output ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        input  ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
               Rs1E, Rs2E, RdE
    );

    modport slave (
        input  ValidD, RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD,
               ALUControlD, ALUSrcD, RD1D, RD2D, PCD, ImmExtD, PCPlus4D,
               Rs1D, Rs2D, RdD,
        output ValidE, RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE,
               ALUControlE, ALUSrcE, RD1E, RD2E, PCE, ImmExtE, PCPlus4E,
               Rs1E, Rs2E, RdE
    );
endinterface

// File: rtl/flop_e.sv
// Decode->Execute pipeline register with hazard stall/flush and a saturating
// count of flush bubbles for performance debug. All outputs come straight from flops.
module flop_e #(
    parameter int XLEN = 32,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            StallE,
    input  logic            FlushE,
    flop_e_if.slave         de,
    output logic [CNTW-1:0] BubbleCnt
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [1:0]      result_src;
        logic            mem_write;
        logic            jump;
        logic            branch;
        logic [2:0]      alu_control;
        logic            alu_src;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm_ext;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
    } de_fields_t;

    localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

    de_fields_t      pipe_in_s;
    de_fields_t      pipe_d;
    de_fields_t      pipe_q;
    logic [CNTW-1:0] bubble_cnt_d;
    logic [CNTW-1:0] bubble_cnt_q;

    assign pipe_in_s = {de.ValidD, de.RegWriteD, de.ResultSrcD, de.MemWriteD,
                        de.JumpD, de.BranchD, de.ALUControlD, de.ALUSrcD,
                        de.RD1D, de.RD2D, de.PCD, de.ImmExtD, de.PCPlus4D,
                        de.Rs1D, de.Rs2D, de.RdD};

    // A bubble is the all-zero entry: invalid and with every side-effect control low.
    always_comb begin
        pipe_d = pipe_q;
        if (FlushE) begin
            pipe_d = '0;
        end else if (StallE) begin
            pipe_d = pipe_q;
        end else begin
            pipe_d = pipe_in_s;
        end
    end

    // Bubble counter counts flushes even when a stall is also requested, and never wraps.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (FlushE && (bubble_cnt_q != CNT_MAX)) begin
            bubble_cnt_d = bubble_cnt_q + CNTW'(1'b1);
        end else begin
            bubble_cnt_d = bubble_cnt_q;
        end
    end

    // State registers; reset overrides flush and stall on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_q       <= '0;
            bubble_cnt_q <= '0;
        end else begin
            pipe_q       <= pipe_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign {de.ValidE, de.RegWriteE, de.ResultSrcE, de.MemWriteE,
            de.JumpE, de.BranchE, de.ALUControlE, de.ALUSrcE,
            de.RD1E, de.RD2E, de.PCE, de.ImmExtE, de.PCPlus4E,
            de.Rs1E, de.Rs2E, de.RdE} = pipe_q;

    assign BubbleCnt = bubble_cnt_q;

endmodule

// File: tb/tb_flop_e.sv
// Bench for flop_e: directed scenarios then random stall/flush/reset traffic, checked
// against a record-level model; a second instance with CNTW=2 exercises saturation.
module tb_flop_e;

    typedef struct packed {
        logic        valid;
        logic        reg_write;
        logic [1:0]  result_src;
        logic        mem_write;
        logic        jump;
        logic        branch;
        logic [2:0]  alu_control;
        logic        alu_src;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
        logic [31:0] imm_ext;
        logic [31:0] pc_plus4;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    rec_t        drv;
    rec_t        exp_rec;
    rec_t        obs16;
    rec_t        obs2;
    logic [15:0] cnt16;
    logic [1:0]  cnt2;
    int          n16;
    int          n2;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    flop_e_if #(.XLEN(32)) bus16 ();
    flop_e_if #(.XLEN(32)) bus2 ();

    assign {bus16.ValidD, bus16.RegWriteD, bus16.ResultSrcD, bus16.MemWriteD,
            bus16.JumpD, bus16.BranchD, bus16.ALUControlD, bus16.ALUSrcD,
            bus16.RD1D, bus16.RD2D, bus16.PCD, bus16.ImmExtD, bus16.PCPlus4D,
            bus16.Rs1D, bus16.Rs2D, bus16.RdD} = drv;
    assign {bus2.ValidD, bus2.RegWriteD, bus2.ResultSrcD, bus2.MemWriteD,
            bus2.JumpD, bus2.BranchD, bus2.ALUControlD, bus2.ALUSrcD,
            bus2.RD1D, bus2.RD2D, bus2.PCD, bus2.ImmExtD, bus2.PCPlus4D,
            bus2.Rs1D, bus2.Rs2D, bus2.RdD} = drv;
    assign obs16 = {bus16.ValidE, bus16.RegWriteE, bus16.ResultSrcE, bus16.MemWriteE,
                    bus16.JumpE, bus16.BranchE, bus16.ALUControlE, bus16.ALUSrcE,
                    bus16.RD1E, bus16.RD2E, bus16.PCE, bus16.ImmExtE, bus16.PCPlus4E,
                    bus16.Rs1E, bus16.Rs2E, bus16.RdE};
    assign obs2 = {bus2.ValidE, bus2.RegWriteE, bus2.ResultSrcE, bus2.MemWriteE,
                   bus2.JumpE, bus2.BranchE, bus2.ALUControlE, bus2.ALUSrcE,
                   bus2.RD1E, bus2.RD2E, bus2.PCE, bus2.ImmExtE, bus2.PCPlus4E,
                   bus2.Rs1E, bus2.Rs2E, bus2.RdE};

    flop_e #(.XLEN(32), .CNTW(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .StallE   (stall),
        .FlushE   (flush),
        .de       (bus16),
        .BubbleCnt(cnt16)
    );

    flop_e #(.XLEN(32), .CNTW(2)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .StallE   (stall),
        .FlushE   (flush),
        .de       (bus2),
        .BubbleCnt(cnt2)
    );

    function automatic rec_t rand_rec();
        logic [191:0] v;
        v = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return v[185:0];
    endfunction

    task automatic chk(input string tag, input logic [185:0] obs, input logic [185:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock edge: advance the model with the inputs presented at the edge, then compare.
    task automatic step(input string tag);
        @(posedge clk);
        #1;
        if (reset) begin
            exp_rec = '0;
            n16 = 0;
            n2 = 0;
        end else if (flush) begin
            exp_rec = '0;
            if (n16 < 65535) n16++;
            if (n2 < 3) n2++;
        end else if (!stall) begin
            exp_rec = drv;
        end
        chk({tag, "/e16"}, obs16, exp_rec);
        chk({tag, "/e2"}, obs2, exp_rec);
        chk({tag, "/cnt16"}, 186'(cnt16), 186'(n16));
        chk({tag, "/cnt2"}, 186'(cnt2), 186'(n2));
    endtask

    initial begin
        int exp5 [5];
        exp5 = '{1, 2, 3, 3, 3};
        exp_rec = '0;
        n16 = 0;
        n2 = 0;

        // Reset for two cycles with busy D inputs.
        reset = 1'b1;
        stall = 1'b0;
        flush = 1'b0;
        drv = rand_rec();
        drv.valid = 1'b1;
        drv.rd1 = 32'hFFFF_FFFF;
        step("reset0");
        drv = rand_rec();
        step("reset1");
        chk("reset_zero", obs16, 186'(0));
        chk("reset_cnt", 186'(cnt16), 186'(0));

        // Plain load.
        reset = 1'b0;
        drv = rand_rec();
        drv.reg_write = 1'b1;
        drv.result_src = 2'b01;
        drv.rd1 = 32'hDEAD_BEEF;
        drv.rd = 5'd7;
        drv.valid = 1'b1;
        step("load");
        chk("load_rd1", 186'(obs16.rd1), 186'(32'hDEAD_BEEF));
        chk("load_rd", 186'(obs16.rd), 186'(5'd7));
        chk("load_rs", 186'(obs16.result_src), 186'(2'b01));

        // Stall three cycles while D changes, then release.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv = rand_rec();
            drv.rd1 = 32'h1234_5678;
            step("stall");
            chk("stall_rd1", 186'(obs16.rd1), 186'(32'hDEAD_BEEF));
        end
        stall = 1'b0;
        step("unstall");
        chk("unstall_rd1", 186'(obs16.rd1), 186'(32'h1234_5678));

        // Flush beats stall.
        flush = 1'b1;
        stall = 1'b1;
        drv = rand_rec();
        drv.mem_write = 1'b1;
        drv.valid = 1'b1;
        step("flush");
        chk("flush_memw", 186'(obs16.mem_write), 186'(0));
        chk("flush_valid", 186'(obs16.valid), 186'(0));
        chk("flush_rd1", 186'(obs16.rd1), 186'(0));
        chk("flush_cnt", 186'(cnt16), 186'(1));

        // Fresh reset, then five back-to-back flushes saturate the 2-bit counter.
        reset = 1'b1;
        flush = 1'b0;
        stall = 1'b0;
        step("reset2");
        reset = 1'b0;
        flush = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drv = rand_rec();
            step("flush5");
            chk("sat_cnt2", 186'(cnt2), 186'(exp5[i]));
            chk("seq_cnt16", 186'(cnt16), 186'(i + 1));
        end

        // Reset arriving during a stall with a loaded entry.
        flush = 1'b0;
        drv = rand_rec();
        drv.valid = 1'b1;
        step("preload");
        stall = 1'b1;
        drv = rand_rec();
        step("hold");
        reset = 1'b1;
        step("rst_in_stall");
        chk("rst_stall_zero", obs16, 186'(0));
        chk("rst_stall_cnt", 186'(cnt16), 186'(0));
        reset = 1'b0;
        stall = 1'b0;
        drv = rand_rec();
        step("after_rst");
        chk("after_rst_load", obs16, drv);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drv = rand_rec();
            reset = ($urandom_range(0, 31) == 0);
            flush = ($urandom_range(0, 5) == 0);
            stall = ($urandom_range(0, 3) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
